// File: rtl/tsbus_arbiter.sv
// Round-robin arbiter/sequencer for an OBUFT tristate output bus with enforced high-Z turnaround.
// Optional burst length limit enabled by defining TSBUS_HOLD_LIMIT_EN (adds MAX_HOLD and the hold counter).
module tsbus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int TURN_CYC = 2
`ifdef TSBUS_HOLD_LIMIT_EN
    ,
    parameter int MAX_HOLD = 16
`endif
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*WIDTH-1:0]     i_data,
    output logic [N_REQ-1:0]           o_gnt,
    output logic [WIDTH-1:0]           o_bus_i,
    output logic [WIDTH-1:0]           o_bus_t,
    output logic                       o_busy,
    output logic [$clog2(N_REQ)-1:0]   o_owner
);

    localparam int OW = $clog2(N_REQ);
    localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0]  bus_i_q, bus_i_d;
    logic [WIDTH-1:0]  bus_t_q, bus_t_d;
    logic              busy_q, busy_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [3:0]        turn_q, turn_d;
`ifdef TSBUS_HOLD_LIMIT_EN
    logic [7:0]        hold_q, hold_d;
`endif
    logic [OW-1:0]     win_s;
    logic              accept_s;
    logic              grant_s;

    // Closest requester above ptr wins: scan far-to-near so the nearest hit overwrites.
    function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [OW-1:0] ptr);
        logic [OW-1:0] win;
        logic [OW-1:0] idx;
        int            tmp;
        win = ptr;
        for (int i = N_REQ; i >= 1; i--) begin
            tmp = int'(ptr) + i;
            if (tmp >= N_REQ) begin
                tmp = tmp - N_REQ;
            end else begin
                tmp = tmp;
            end
            idx = OW'(tmp);
            if (req[idx]) begin
                win = idx;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        gnt_d    = {N_REQ{1'b0}};
        bus_i_d  = {WIDTH{1'b0}};
        bus_t_d  = {WIDTH{1'b1}};
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        turn_d   = turn_q;
`ifdef TSBUS_HOLD_LIMIT_EN
        hold_d   = hold_q;
`endif
        win_s    = rr_pick(i_req, ptr_q);
        accept_s = gnt_q[owner_q] & i_req[owner_q];
        grant_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|i_req) begin
                    grant_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (accept_s) begin
                    bus_i_d = i_data[owner_q*WIDTH +: WIDTH];
                    bus_t_d = {WIDTH{1'b0}};
`ifdef TSBUS_HOLD_LIMIT_EN
                    hold_d = hold_q + 8'd1;
                    // Forced exit: the last word still goes out during the first TURN cycle.
                    if (hold_d == 8'(MAX_HOLD)) begin
                        state_d = S_TURN;
                        turn_d  = TURN_LAST;
                    end else begin
                        gnt_d[owner_q] = 1'b1;
                    end
`else
                    gnt_d[owner_q] = 1'b1;
`endif
                end else begin
                    state_d = S_TURN;
                    turn_d  = TURN_LAST;
                end
            end
            S_TURN: begin
                if (turn_q == 4'd0) begin
                    if (|i_req) begin
                        grant_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    turn_d = turn_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (grant_s) begin
            state_d        = S_DRIVE;
            owner_d        = win_s;
            ptr_d          = win_s;
            gnt_d[win_s]   = 1'b1;
`ifdef TSBUS_HOLD_LIMIT_EN
            hold_d         = 8'd0;
`endif
        end else begin
            ptr_d = ptr_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset floats the bus immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            gnt_q   <= {N_REQ{1'b0}};
            bus_i_q <= {WIDTH{1'b0}};
            bus_t_q <= {WIDTH{1'b1}};
            busy_q  <= 1'b0;
            owner_q <= {OW{1'b0}};
            ptr_q   <= OW'(N_REQ - 1);
            turn_q  <= 4'd0;
`ifdef TSBUS_HOLD_LIMIT_EN
            hold_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            bus_i_q <= bus_i_d;
            bus_t_q <= bus_t_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            turn_q  <= turn_d;
`ifdef TSBUS_HOLD_LIMIT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign o_gnt   = gnt_q;
    assign o_bus_i = bus_i_q;
    assign o_bus_t = bus_t_q;
    assign o_busy  = busy_q;
    assign o_owner = owner_q;

endmodule

// File: doc/tsbus_arbiter.md
Name: tsbus_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8-bit tristate output bus built from per-bit OBUFT cells.
- Shares the bus between N_REQ internal requesters.
- Drives the OBUFT I inputs (o_bus_i) and T inputs (o_bus_t; 1 = high-Z) so that only one requester drives the bus at a time, with enforced high-Z turnaround gaps between bursts.
- Sits between the requester logic and the OBUFT pad ring.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, bus width in bits
- TURN_CYC, 2, high-Z turnaround cycles after a burst (1..15)
- MAX_HOLD, 16, max accepted words per burst (1..255); used only with TSBUS_HOLD_LIMIT_EN

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_req  in  N_REQ  per-requester bus request, level; held high for the whole burst
- i_data  in  N_REQ*WIDTH  requester data; slice r = bits [r*WIDTH +: WIDTH]
- o_gnt  out  N_REQ  one-hot grant / word-accept strobe
- o_bus_i  out  WIDTH  to OBUFT I inputs
- o_bus_t  out  WIDTH  to OBUFT T inputs; all bits equal; 1 = high-Z
- o_busy  out  1  high when state is not IDLE
- o_owner  out  clog2(N_REQ)  index of current or last winner

Behaviour:
- Reset (asynchronous, immediate): state IDLE, o_gnt=0, o_bus_t=all 1, o_bus_i=0, o_busy=0, o_owner=0, RR pointer=N_REQ-1 (requester 0 wins first), hold counter=0.
- All outputs are registered.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - If any i_req: pick winner W by round robin, searching from pointer+1 mod N_REQ upward.
  - Latch W into o_owner and the pointer; next state DRIVE.
  - Latency: req in cycle k -> o_gnt[W]=1 in cycle k+1.
- DRIVE:
  - o_gnt = one-hot(W).
  - A word is accepted in a cycle when o_gnt[W] & i_req[W].
  - Accepted word sampled at cycle k appears on o_bus_i in k+1 with o_bus_t=0 in k+1.
  - In any cycle following a non-accept: o_bus_t=all 1, o_bus_i=0.
  - Exit to TURN next cycle when:
    - i_req[W]=0 in a DRIVE cycle (voluntary release; no word accepted that cycle), or
    - the accept count reaches MAX_HOLD (forced exit, only with the macro).
  - The hold counter clears on entry to DRIVE.
- TURN:
  - Lasts exactly TURN_CYC cycles; o_gnt=0.
  - The bus is high-Z except in the first TURN cycle after a forced exit, which still carries the last word.
  - In the last TURN cycle: if any i_req, re-arbitrate (same rule) and go to DRIVE; else go to IDLE.
- High-Z gap between two bursts:
  - TURN_CYC cycles after a forced exit.
  - TURN_CYC+1 cycles after a voluntary release.
  - Never less than TURN_CYC.
- Requests changing during TURN take effect only at the last TURN cycle. Requests from non-winners are ignored during DRIVE.
- A winner that re-requests immediately is served again only if no other requester is pending (fairness via pointer).
- Reset mid-burst: the bus goes high-Z asynchronously; no partial word is driven after reset deassertion.
- Widths: hold counter 8 bits; turn counter 4 bits; no wrap permitted.

Optional Feature:
- Macro: TSBUS_HOLD_LIMIT_EN.
- Defined: DRIVE is forcibly exited after MAX_HOLD accepted words, even if i_req[W] stays high. W must drop and re-raise i_req, or simply stay high, to compete again after TURN.
- Undefined: the MAX_HOLD parameter and hold counter are not built; a burst lasts until the winner drops i_req.

Test Plan:
- Reset with i_req=4'b1111 held -> o_bus_t=8'hFF, o_gnt=0 during reset. First cycle after release: IDLE decision; next cycle o_gnt=4'b0001, o_owner=0.
- Req1 alone, i_data slice1 = 8'hA5 then 8'h5A for two accepts, then req drops -> o_bus_i=A5, 5A on the two cycles after the accepts, o_bus_t=0 for those two cycles, then 8'hFF for TURN_CYC+1=3 cycles; o_busy falls after TURN.
- All four requesting continuously with each burst of 1 word (req pulse) -> grant order 0,1,2,3,0; a gap of at least 2 high-Z cycles between each pair of driven words.
- TSBUS_HOLD_LIMIT_EN, MAX_HOLD=4, req2 held high alone -> 4 accepts, TURN of 2 cycles (high-Z gap exactly 2), then req2 re-granted. Without the macro -> unbroken burst for 100 cycles.
- i_rst asserted mid-burst on owner 3 -> o_bus_t=8'hFF and o_gnt=0 in the same cycle. After release, requester 0 wins first (pointer reset).
- Req0 drops and req3 rises during TURN, req3 stable at the last TURN cycle -> o_gnt=4'b1000 in the following cycle. All requests drop during TURN -> return to IDLE, o_busy=0.
